// File: rtl/sal_bank_timer.sv
// Per-bank DRAM state/timing tracker: legal-command flags for the scheduler.
// Flags are combinational from registered state; illegal_cmd pulses one cycle after the offending command.
module sal_bank_timer #(
  parameter int ROW_AW = 14,
  parameter int TW     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [TW-1:0]     t_rcd,
  input  logic [TW-1:0]     t_rp,
  input  logic [TW-1:0]     t_ras,
  input  logic [TW-1:0]     t_rfc,
  input  logic [TW-1:0]     t_rtp,
  input  logic [TW-1:0]     t_wtp,
  input  logic              cmd_valid,
  input  logic [2:0]        cmd_type,
  input  logic [ROW_AW-1:0] cmd_row,
  output logic              act_ok,
  output logic              rdwr_ok,
  output logic              pre_ok,
  output logic              ref_ok,
  output logic              is_open,
  output logic [ROW_AW-1:0] open_row,
  output logic              illegal_cmd
);

  typedef enum logic [1:0] {
    CLOSED      = 2'd0,
    OPEN        = 2'd1,
    PRECHARGING = 2'd2,
    REFRESHING  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     rcd_cnt_q, rcd_cnt_d;
  logic [TW-1:0]     ras_cnt_q, ras_cnt_d;
  logic [TW-1:0]     rp_cnt_q, rp_cnt_d;
  logic [TW-1:0]     pw_cnt_q, pw_cnt_d;
  logic [ROW_AW-1:0] open_row_q, open_row_d;
  logic              illegal_q, illegal_d;

  logic is_act, is_rd, is_wr, is_pre, is_ref;
  logic [TW-1:0] pw_dec, rtp_ld, wtp_ld;

  // Load value so the gated command is first legal max(T,1) cycles after issue.
  function automatic logic [TW-1:0] load_val(input logic [TW-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

  function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] c);
    return (c == '0) ? '0 : c - 1'b1;
  endfunction

  assign act_ok      = (state_q == CLOSED);
  assign ref_ok      = (state_q == CLOSED);
  assign rdwr_ok     = (state_q == OPEN) && (rcd_cnt_q == '0);
  assign pre_ok      = (state_q == CLOSED) ||
                       ((state_q == OPEN) && (ras_cnt_q == '0) && (pw_cnt_q == '0));
  assign is_open     = (state_q == OPEN);
  assign open_row    = open_row_q;
  assign illegal_cmd = illegal_q;

  assign is_act = cmd_valid && (cmd_type == 3'd1);
  assign is_rd  = cmd_valid && (cmd_type == 3'd2);
  assign is_wr  = cmd_valid && (cmd_type == 3'd3);
  assign is_pre = cmd_valid && (cmd_type == 3'd4);
  assign is_ref = cmd_valid && (cmd_type == 3'd5);

  assign pw_dec = sat_dec(pw_cnt_q);
  assign rtp_ld = load_val(t_rtp);
  assign wtp_ld = load_val(t_wtp);

  always_comb begin
    state_d    = state_q;
    rcd_cnt_d  = sat_dec(rcd_cnt_q);
    ras_cnt_d  = sat_dec(ras_cnt_q);
    rp_cnt_d   = sat_dec(rp_cnt_q);
    pw_cnt_d   = pw_dec;
    open_row_d = open_row_q;
    illegal_d  = 1'b0;

    if (((state_q == PRECHARGING) || (state_q == REFRESHING)) && (rp_cnt_q == '0)) begin
      state_d = CLOSED;
    end

    if (is_act) begin
      if (act_ok) begin
        state_d    = OPEN;
        open_row_d = cmd_row;
        rcd_cnt_d  = load_val(t_rcd);
        ras_cnt_d  = load_val(t_ras);
        pw_cnt_d   = '0;
      end else begin
        illegal_d = 1'b1;
      end
    end

    // Read/write extend the precharge hold-off; never shorten it.
    if (is_rd || is_wr) begin
      if (rdwr_ok) begin
        if (is_rd) pw_cnt_d = (rtp_ld > pw_dec) ? rtp_ld : pw_dec;
        else       pw_cnt_d = (wtp_ld > pw_dec) ? wtp_ld : pw_dec;
      end else begin
        illegal_d = 1'b1;
      end
    end

    if (is_pre) begin
      if (!pre_ok) begin
        illegal_d = 1'b1;
      end else if (state_q == OPEN) begin
        state_d  = PRECHARGING;
        rp_cnt_d = load_val(t_rp);
      end
    end

    if (is_ref) begin
      if (ref_ok) begin
        state_d  = REFRESHING;
        rp_cnt_d = load_val(t_rfc);
      end else begin
        illegal_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CLOSED;
      rcd_cnt_q  <= '0;
      ras_cnt_q  <= '0;
      rp_cnt_q   <= '0;
      pw_cnt_q   <= '0;
      open_row_q <= '0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rcd_cnt_q  <= rcd_cnt_d;
      ras_cnt_q  <= ras_cnt_d;
      rp_cnt_q   <= rp_cnt_d;
      pw_cnt_q   <= pw_cnt_d;
      open_row_q <= open_row_d;
      illegal_q  <= illegal_d;
    end
  end

endmodule

// File: tb/tb_sal_bank_timer.sv
// Bench for sal_bank_timer: directed scenarios plus randomized commands against a timestamp-based model.
module tb_sal_bank_timer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  t_rcd, t_rp, t_ras, t_rfc, t_rtp, t_wtp;
  logic        cmd_valid;
  logic [2:0]  cmd_type;
  logic [13:0] cmd_row;
  logic        act_ok, rdwr_ok, pre_ok, ref_ok, is_open, illegal_cmd;
  logic [13:0] open_row;

  int n_tests = 0;
  int n_fail  = 0;

  sal_bank_timer #(.ROW_AW(14), .TW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .t_rcd(t_rcd), .t_rp(t_rp), .t_ras(t_ras), .t_rfc(t_rfc), .t_rtp(t_rtp), .t_wtp(t_wtp),
    .cmd_valid(cmd_valid), .cmd_type(cmd_type), .cmd_row(cmd_row),
    .act_ok(act_ok), .rdwr_ok(rdwr_ok), .pre_ok(pre_ok), .ref_ok(ref_ok),
    .is_open(is_open), .open_row(open_row), .illegal_cmd(illegal_cmd)
  );

  always #5 clk = ~clk;

  // Model: bank status expressed as absolute cycle numbers at which things become legal.
  int  cyc;
  bit  m_open, m_busy, exp_ill;
  int  m_row, m_rdwr_at, m_pre_at, m_close_at;

  function automatic int eff(input logic [7:0] t);
    return (t == 8'd0) ? 1 : int'(t);
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic set_timing(input int rcd, input int rp, input int ras,
                            input int rfc, input int rtp, input int wtp);
    t_rcd = 8'(rcd); t_rp = 8'(rp); t_ras = 8'(ras);
    t_rfc = 8'(rfc); t_rtp = 8'(rtp); t_wtp = 8'(wtp);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_act"},  act_ok, 1);
    check({tag, "_ref"},  ref_ok, 1);
    check({tag, "_pre"},  pre_ok, 1);
    check({tag, "_rdwr"}, rdwr_ok, 0);
    check({tag, "_open"}, is_open, 0);
    check({tag, "_row"},  open_row, 0);
    check({tag, "_ill"},  illegal_cmd, 0);
  endtask

  // Reset asserted away from the clock edge; outputs must change without a clock.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_type = 3'd0; cmd_row = '0;
    #1;
    check_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    cyc = 0; m_open = 0; m_busy = 0; exp_ill = 0;
    m_row = 0; m_rdwr_at = 0; m_pre_at = 0; m_close_at = 0;
  endtask

  // One cycle: compare model against DUT, present a command, update model, advance.
  task automatic step(input bit v, input logic [2:0] t, input logic [13:0] r);
    bit closed, e_rdwr, e_pre, nxt_ill;
    if (m_busy && cyc >= m_close_at) m_busy = 0;
    closed = !m_open && !m_busy;
    e_rdwr = m_open && (cyc >= m_rdwr_at);
    e_pre  = closed || (m_open && (cyc >= m_pre_at));
    check("act_ok",  act_ok, closed);
    check("ref_ok",  ref_ok, closed);
    check("rdwr_ok", rdwr_ok, e_rdwr);
    check("pre_ok",  pre_ok, e_pre);
    check("is_open", is_open, m_open);
    if (m_open) check("open_row", open_row, m_row);
    check("illegal", illegal_cmd, exp_ill);

    cmd_valid = v; cmd_type = t; cmd_row = r;
    nxt_ill = 0;
    if (v) begin
      case (t)
        3'd1: if (closed) begin
                m_open = 1; m_row = int'(r);
                m_rdwr_at = cyc + eff(t_rcd);
                m_pre_at  = cyc + eff(t_ras);
              end else nxt_ill = 1;
        3'd2: if (e_rdwr) begin
                if (cyc + eff(t_rtp) > m_pre_at) m_pre_at = cyc + eff(t_rtp);
              end else nxt_ill = 1;
        3'd3: if (e_rdwr) begin
                if (cyc + eff(t_wtp) > m_pre_at) m_pre_at = cyc + eff(t_wtp);
              end else nxt_ill = 1;
        3'd4: if (!e_pre) nxt_ill = 1;
              else if (m_open) begin
                m_open = 0; m_busy = 1; m_close_at = cyc + eff(t_rp) + 1;
              end
        3'd5: if (closed) begin
                m_busy = 1; m_close_at = cyc + eff(t_rfc) + 1;
              end else nxt_ill = 1;
        default: ;
      endcase
    end
    @(posedge clk); #1;
    cyc++;
    exp_ill = nxt_ill;
    cmd_valid = 1'b0; cmd_type = 3'd0;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step(1'b0, 3'd0, 14'd0);
  endtask

  initial begin
    cmd_valid = 1'b0; cmd_type = 3'd0; cmd_row = '0;
    set_timing(3, 3, 8, 20, 2, 6);
    cyc = 0;
    #12;
    do_reset();
    check_reset_vals("idle");

    // ACT then WR at 3: write-to-precharge outlasts tRAS
    do_reset();
    step(1'b1, 3'd1, 14'h123);
    check("a_open", is_open, 1);
    check("a_row", open_row, 14'h123);
    run_to(2); check("a_rdwr2", rdwr_ok, 0);
    run_to(3); check("a_rdwr3", rdwr_ok, 1);
    step(1'b1, 3'd3, 14'd0);
    run_to(8); check("a_pre8", pre_ok, 0);
    run_to(9); check("a_pre9", pre_ok, 1);

    // ACT then RD at 3: tRAS governs; then PRE at 8
    do_reset();
    step(1'b1, 3'd1, 14'h0aa);
    run_to(3); step(1'b1, 3'd2, 14'd0);
    run_to(7); check("b_pre7", pre_ok, 0);
    run_to(8); check("b_pre8", pre_ok, 1);
    step(1'b1, 3'd4, 14'd0);
    run_to(11); check("b_act11", act_ok, 0);
    run_to(12); check("b_act12", act_ok, 1);

    // Refresh from closed
    do_reset();
    step(1'b1, 3'd5, 14'd0);
    run_to(20); check("c_act20", act_ok, 0); check("c_ref20", ref_ok, 0);
    run_to(21); check("c_act21", act_ok, 1); check("c_ref21", ref_ok, 1);

    // Early RD is flagged and does not disturb timing
    do_reset();
    step(1'b1, 3'd1, 14'h3ff);
    step(1'b1, 3'd2, 14'd0);
    check("d_ill2", illegal_cmd, 1);
    check("d_rdwr2", rdwr_ok, 0);
    step(1'b0, 3'd0, 14'd0);
    check("d_ill3", illegal_cmd, 0);
    check("d_rdwr3", rdwr_ok, 1);

    // Reset in the middle of a refresh
    do_reset();
    step(1'b1, 3'd5, 14'd0);
    run_to(5);
    check("e_busy", act_ok, 0);
    do_reset();

    // Randomized traffic with timings changing every cycle (only load-time values matter)
    for (int i = 0; i < 4000; i++) begin
      set_timing($urandom_range(12), $urandom_range(12), $urandom_range(12),
                 $urandom_range(12), $urandom_range(12), $urandom_range(12));
      if ((i % 1000) == 999) do_reset();
      step($urandom_range(9) < 6, 3'($urandom_range(7)), 14'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
